// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces an active-low push button into a clean level
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic b_in,
  output logic b_out,
  output logic busy
);
  // bit 1 = accepted level is low, bit 0 = qualifying a change
  localparam logic [1:0] S_HIGH = 2'b00;
  localparam logic [1:0] S_CHK_LO = 2'b01;
  localparam logic [1:0] S_LOW = 2'b10;
  localparam logic [1:0] S_CHK_HI = 2'b11;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic s;
  assign s = sync_q[1];
  // two-flop synchronizer, state and stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      state_q <= S_HIGH;
      cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], b_in};
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // any opposite sample while qualifying drops back and clears the count
  always_comb begin
    state_d = S_HIGH;
    cnt_d = '0;
    case (state_q)
      S_HIGH: if (!s) begin
        state_d = S_CHK_LO;
        cnt_d = CNT_W'(1);
      end
      S_CHK_LO: if (s) state_d = S_HIGH;
        else if (cnt_q == LAST) state_d = S_LOW;
        else begin
          state_d = S_CHK_LO;
          cnt_d = cnt_q + 1'b1;
        end
      S_LOW: if (s) begin
        state_d = S_CHK_HI;
        cnt_d = CNT_W'(1);
      end else state_d = S_LOW;
      S_CHK_HI: if (!s) state_d = S_LOW;
        else if (cnt_q == LAST) state_d = S_HIGH;
        else begin
          state_d = S_CHK_HI;
          cnt_d = cnt_q + 1'b1;
        end
      default: ;
    endcase
  end
  assign b_out = ~state_q[1];
  assign busy = state_q[0];
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of the debouncer with DEBOUNCE_CYCLES=4
module tb_button_debouncer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_in = 1'b1;
  logic b_out, busy;
  int passed = 0;
  int total = 0;
  int failed = 0;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .b_in(b_in), .b_out(b_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int falls;
    int bad_out;
    int bad_cnt;
    logic prev;
    logic seen_busy;
    // 1. reset, then idle released
    rst = 1'b1;
    b_in = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_b_out", b_out, 1);
      check("idle_busy", busy, 0);
      tick();
    end
    // 2. clean press: edge E samples the new low level
    b_in = 1'b0;
    tick();
    check("press_E_busy", busy, 0);
    tick();
    check("press_E1_busy", busy, 0);
    tick();
    check("press_E2_busy", busy, 1);
    check("press_E2_b_out", b_out, 1);
    tick();
    tick();
    check("press_E4_b_out", b_out, 1);
    check("press_E4_busy", busy, 1);
    tick();
    check("press_E5_b_out", b_out, 0);
    check("press_E5_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("press_hold_b_out", b_out, 0);
    end
    // 4. bouncy release from S_LOW: high 2, low 1, then held high
    b_in = 1'b1;
    tick();
    check("rel_bounce_b_out", b_out, 0);
    tick();
    check("rel_bounce_b_out", b_out, 0);
    b_in = 1'b0;
    tick();
    check("rel_bounce_b_out", b_out, 0);
    b_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rel_final_b_out", b_out, (i == 5) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) tick();
    check("rel_settled_busy", busy, 0);
    // 3. bounce: low 3, high 1, low 2, high 5 never changes b_out
    seen_busy = 1'b0;
    b_in = 1'b0;
    for (int i = 0; i < 11; i++) begin
      b_in = (i < 3 || i == 4 || i == 5) ? 1'b0 : 1'b1;
      tick();
      check("bounce_b_out", b_out, 1);
      if (busy) seen_busy = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bounce_tail_b_out", b_out, 1);
      if (busy) seen_busy = 1'b1;
    end
    check("bounce_busy_pulsed", seen_busy, 1);
    check("bounce_final_busy", busy, 0);
    check("bounce_final_state", dut.state_q, 0);
    // 5. reset during S_CHK_LO with cnt=2
    b_in = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("mid_busy", busy, 1);
    check("mid_cnt", dut.cnt_q, 2);
    rst = 1'b1;
    tick();
    check("rst_mid_b_out", b_out, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cnt", dut.cnt_q, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("requal_b_out", b_out, (i == 5) ? 0 : 1);
    end
    // 6. long hold low starting from released
    b_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("pre_hold_b_out", b_out, 1);
    b_in = 1'b0;
    falls = 0;
    bad_out = 0;
    bad_cnt = 0;
    prev = b_out;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (prev && !b_out) falls++;
      prev = b_out;
      if (i >= 5 && b_out !== 1'b0) bad_out++;
      if (i >= 5 && dut.cnt_q !== 3'd0) bad_cnt++;
    end
    check("hold_falls", falls, 1);
    check("hold_bad_b_out", bad_out, 0);
    check("hold_bad_cnt", bad_cnt, 0);
    check("hold_end_b_out", b_out, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
